// File: rtl/nlx_sram_pkg.sv
// Shared types, constants and the byte parity helper for the nlx_sram responder.
package nlx_sram_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  localparam int unsigned NLX_DATA_W = 32;
  localparam int unsigned NLX_BE_W   = 4;

  // Even-parity bit for one byte: XOR of all its bits.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/nlx_sram_array.sv
// Plain single-port storage: per-lane write enables, registered read port with
// synchronous clear. No reset on the array itself.
module nlx_sram_array #(
  parameter int unsigned LANE_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic                      clk,
  input  logic [LANES-1:0]          we,
  input  logic                      re,
  input  logic                      clr,
  input  logic [AW-1:0]             addr,
  input  logic [LANES*LANE_W-1:0]   wdata,
  output logic [LANES*LANE_W-1:0]   rdata
);

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/nlx_sram.sv
// nlx_sram_resp: SRAM responder with post-reset clear sweep and OOR detection.
// Optional per-byte parity storage/check enabled by defining NLX_SRAM_PARITY_EN.
module nlx_sram_resp
  import nlx_sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 65536
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NLX_BE_W-1:0]   we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [NLX_DATA_W-1:0] wdata,
  output logic [NLX_DATA_W-1:0] rdata,
  output logic                  init_busy,
  output logic                  oor_err
`ifdef NLX_SRAM_PARITY_EN
  ,
  output logic                  par_err,
  input  logic                  par_inj
`endif
);

`ifdef NLX_SRAM_PARITY_EN
  localparam int unsigned LANE_W = 9;
`else
  localparam int unsigned LANE_W = 8;
`endif
  localparam int unsigned ARR_W = NLX_BE_W * LANE_W;

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

  state_e            state, state_n;
  logic [ADDR_W:0]   ptr, ptr_n;
  logic              in_range;
  logic              is_write;

  logic [NLX_BE_W-1:0] arr_we;
  logic                arr_re;
  logic                arr_clr;
  logic [ADDR_W-1:0]   arr_addr;
  logic [ARR_W-1:0]    arr_wdata;
  logic [ARR_W-1:0]    arr_rdata;
  logic [ARR_W-1:0]    lane_wdata;

  assign in_range  = ({1'b0, addr} < DEPTH_X);
  assign is_write  = (we != '0);
  assign init_busy = (state == INIT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    case (state)
      INIT: begin
        if (ptr == LAST) state_n = RUN;
        else             ptr_n   = ptr + 1'b1;
      end
      RUN:     state_n = RUN;
      default: state_n = INIT;
    endcase
  end

  // Bus bytes packed into storage lanes; with parity each lane is {par, byte}.
  always_comb begin
    lane_wdata = '0;
    for (int unsigned i = 0; i < NLX_BE_W; i++) begin
      lane_wdata[i*LANE_W +: 8] = wdata[i*8 +: 8];
`ifdef NLX_SRAM_PARITY_EN
      lane_wdata[i*LANE_W + 8] = byte_par(wdata[i*8 +: 8]) ^ par_inj;
`endif
    end
  end

  // Clearing the read register covers reset, the whole sweep and OOR reads,
  // so rdata (and parity status derived from it) returns to 0 in those cases.
  always_comb begin
    arr_we    = '0;
    arr_re    = 1'b0;
    arr_clr   = 1'b0;
    arr_addr  = addr;
    arr_wdata = lane_wdata;
    if (!rstn) begin
      arr_clr = 1'b1;
    end else if (state == INIT) begin
      arr_we    = '1;
      arr_clr   = 1'b1;
      arr_addr  = ptr[ADDR_W-1:0];
      arr_wdata = '0;
    end else if (in_range) begin
      if (is_write) arr_we = we;
      else          arr_re = 1'b1;
    end else if (!is_write) begin
      arr_clr = 1'b1;
    end
  end

  nlx_sram_array #(
    .LANE_W (LANE_W),
    .LANES  (NLX_BE_W),
    .DEPTH  (DEPTH),
    .AW     (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NLX_BE_W; i++) begin
      rdata[i*8 +: 8] = arr_rdata[i*LANE_W +: 8];
    end
  end

`ifdef NLX_SRAM_PARITY_EN
  // Check is a pure function of the registered word, so it updates and holds
  // exactly when rdata does.
  always_comb begin
    par_err = 1'b0;
    for (int unsigned i = 0; i < NLX_BE_W; i++) begin
      if (byte_par(arr_rdata[i*LANE_W +: 8]) != arr_rdata[i*LANE_W + 8]) par_err = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn)              oor_err <= 1'b0;
    else if (state == INIT) oor_err <= 1'b0;
    else                    oor_err <= !in_range;
  end

endmodule

// File: tb/tb_nlx_sram_resp.sv
// Scoreboard bench for nlx_sram_resp (DEPTH=16); parity cases need NLX_SRAM_PARITY_EN.
module tb_nlx_sram_resp;
  import nlx_sram_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  we = '0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        init_busy;
  logic        oor_err;
  logic        par_err_s;
`ifdef NLX_SRAM_PARITY_EN
  logic        par_err;
  logic        par_inj = 1'b0;
  assign par_err_s = par_err;
`else
  assign par_err_s = 1'b0;
`endif

  nlx_sram_resp #(
    .ADDR_W (16),
    .DEPTH  (16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .init_busy (init_busy),
    .oor_err   (oor_err)
`ifdef NLX_SRAM_PARITY_EN
    ,
    .par_err   (par_err),
    .par_inj   (par_inj)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        oor;
    logic        busy;
    logic        par;
    logic        chk_par;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Monitor: every cycle of stimulus pushes one entry; it is due just after
  // the rising edge that samples that stimulus.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (rdata !== e.rd || oor_err !== e.oor || init_busy !== e.busy ||
          (e.chk_par && par_err_s !== e.par)) begin
        failures++;
        $display("FAIL %s: got rdata=%08h oor=%b busy=%b par=%b, want rdata=%08h oor=%b busy=%b par=%b",
                 e.name, rdata, oor_err, init_busy, par_err_s, e.rd, e.oor, e.busy, e.par);
      end
    end
  end

  task automatic cyc(input logic r, input logic [3:0] w, input logic [15:0] a,
                     input logic [31:0] d, input logic inj,
                     input logic [31:0] erd, input logic eoor, input logic ebusy,
                     input logic epar, input logic cpar, input string nm);
    exp_t e;
    @(negedge clk);
    rstn  = r;
    we    = w;
    addr  = a;
    wdata = d;
`ifdef NLX_SRAM_PARITY_EN
    par_inj = inj;
`else
    if (inj) $display("note: par_inj ignored in this build");
`endif
    e.rd = erd; e.oor = eoor; e.busy = ebusy; e.par = epar; e.chk_par = cpar; e.name = nm;
    q.push_back(e);
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] erd, input logic eoor, input string nm);
    cyc(1'b1, 4'h0, a, 32'h0, 1'b0, erd, eoor, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic wr(input logic [3:0] w, input logic [15:0] a, input logic [31:0] d,
                    input logic [31:0] hold, input logic eoor, input string nm);
    cyc(1'b1, w, a, d, 1'b0, hold, eoor, 1'b0, 1'b0, 1'b0, nm);
  endtask

  // Release reset and run the 16-edge sweep; busy drops on the 16th edge.
  task automatic sweep(input string nm);
    for (int k = 1; k <= 16; k++) begin
      if (k == 3)
        cyc(1'b1, 4'hF, 16'd3, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, (k < 16), 1'b0, 1'b0, nm);
      else if (k == 5)
        cyc(1'b1, 4'h0, 16'd20, 32'h0, 1'b0, 32'h0, 1'b0, (k < 16), 1'b0, 1'b0, nm);
      else
        cyc(1'b1, 4'h0, 16'd1, 32'h0, 1'b0, 32'h0, 1'b0, (k < 16), 1'b0, 1'b0, nm);
    end
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
      end
    join_none

    for (int k = 0; k < 10; k++)
      cyc(1'b0, 4'h0, 16'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, "reset_state");
    sweep("init_sweep");

    for (int a = 0; a < 16; a++) rd(16'(a), 32'h0, 1'b0, "cleared_word");

    wr(4'hF,    16'd5, 32'hAABBCCDD, 32'h0, 1'b0, "be_write_full");
    wr(4'b0101, 16'd5, 32'h11223344, 32'h0, 1'b0, "be_write_partial");
    rd(16'd5, 32'hAA22CC44, 1'b0, "be_readback");

    wr(4'hF, 16'd7, 32'h12345678, 32'hAA22CC44, 1'b0, "b2b_write_hold");
    rd(16'd7, 32'h12345678, 1'b0, "b2b_read");

    wr(4'hF, 16'd1, 32'h01010101, 32'h12345678, 1'b0, "wr_addr1");
    wr(4'hF, 16'd2, 32'h02020202, 32'h12345678, 1'b0, "wr_addr2");
    rd(16'd1, 32'h01010101, 1'b0, "interleave_1a");
    rd(16'd2, 32'h02020202, 1'b0, "interleave_2");
    rd(16'd1, 32'h01010101, 1'b0, "interleave_1b");

    wr(4'hF, 16'd20, 32'hCAFEF00D, 32'h01010101, 1'b1, "oor_write");
    rd(16'd4, 32'h0, 1'b0, "oor_write_no_alias");
    rd(16'd1, 32'h01010101, 1'b0, "pre_oor_read");
    rd(16'd20, 32'h0, 1'b1, "oor_read");
    rd(16'd5, 32'hAA22CC44, 1'b0, "oor_pulse_ends");
    rd(16'd15, 32'h0, 1'b0, "last_addr_in_range");
    rd(16'd16, 32'h0, 1'b1, "first_addr_oor");

    wr(4'hF, 16'd2, 32'hFFFFFFFF, 32'h0, 1'b0, "rst_pre_write");
    rd(16'd2, 32'hFFFFFFFF, 1'b0, "rst_pre_read");
    cyc(1'b0, 4'h0, 16'd2, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, "midrun_reset");
    sweep("resweep");
    rd(16'd2, 32'h0, 1'b0, "post_reset_cleared");
    rd(16'd3, 32'h0, 1'b0, "init_write_ignored");

`ifdef NLX_SRAM_PARITY_EN
    cyc(1'b1, 4'b0001, 16'd4, 32'h000000FF, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "par_inj_write");
    cyc(1'b1, 4'h0, 16'd4, 32'h0, 1'b0, 32'h000000FF, 1'b0, 1'b0,
        (byte_par(8'hFF) ^ 1'b1) != byte_par(8'hFF), 1'b1, "par_err_set");
    cyc(1'b1, 4'b0001, 16'd4, 32'h000000FF, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b1, 1'b1, "par_err_held");
    cyc(1'b1, 4'h0, 16'd4, 32'h0, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b1, "par_err_clear");
`endif

    for (int k = 0; k < 5 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
